// File: rtl/spi_master.sv
// Byte-wide SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, start/done handshake.
// Optional: define SPI_MASTER_BURST_EN to chain transfers from the last TRAIL cycle without releasing ss.
module spi_master #(
    parameter int DIV   = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done,
    output logic             ss,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso
);

    localparam int HW = $clog2(DIV + 1);
    localparam int BW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        XFER,
        TRAIL
    } state_t;

    state_t           state_q, state_d;
    logic [HW-1:0]    half_q, half_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             sclk_q, sclk_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             done_q, done_d;
    logic             half_last;

    assign half_last = (half_q == HW'(DIV - 1));

    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        bit_d   = bit_q;
        sclk_d  = sclk_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    tx_d    = data_in;
                    rx_d    = '0;
                    bit_d   = '0;
                    half_d  = '0;
                    state_d = LEAD;
                end
            end
            LEAD: begin
                bit_d = '0;
                if (half_last) begin
                    half_d  = '0;
                    state_d = XFER;
                end else begin
                    half_d = half_q + HW'(1);
                end
            end
            XFER: begin
                if (half_last) begin
                    half_d = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        rx_d = {rx_q[WIDTH-2:0], miso};
                    end else begin
                        bit_d = bit_q + BW'(1);
                        // The last bit stays on mosi through TRAIL, so no shift on the final fall.
                        if (bit_q == BW'(WIDTH - 1)) begin
                            state_d = TRAIL;
                        end else begin
                            tx_d = {tx_q[WIDTH-2:0], 1'b0};
                        end
                    end
                end else begin
                    half_d = half_q + HW'(1);
                end
            end
            TRAIL: begin
                if (half_last) begin
                    half_d  = '0;
                    done_d  = 1'b1;
                    dout_d  = rx_q;
                    state_d = IDLE;
`ifdef SPI_MASTER_BURST_EN
                    if (start) begin
                        tx_d    = data_in;
                        rx_d    = '0;
                        bit_d   = '0;
                        state_d = XFER;
                    end
`endif
                end else begin
                    half_d = half_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            half_q  <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
        end
    end

    assign ss       = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign sclk     = sclk_q;
    assign mosi     = (state_q == IDLE) ? 1'b0 : tx_q[WIDTH-1];
    assign done     = done_q;
    assign data_out = dout_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: three instances (DIV=4,2,1) checked every cycle against a timing model
// derived from the transfer's cycle arithmetic, plus directed literal checks.
module tb_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst, start, miso_w, busy_w, done_w, ss_w, sclk_w, mosi_w;
    logic [7:0] din    [3];
    logic [7:0] dout_w [3];
    int         mode   [3];   // 0 loopback, 1 constant 1, 2 pattern aligned to sclk rises
    logic [7:0] pat    [3];
    logic       chk_en = 1'b0;
    int         n_cmp  = 0;
    int         n_bad  = 0;

    spi_master #(.DIV(4), .WIDTH(8)) u_div4 (
        .clk(clk), .rst(rst[0]), .start(start[0]), .data_in(din[0]), .data_out(dout_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .ss(ss_w[0]), .sclk(sclk_w[0]), .mosi(mosi_w[0]),
        .miso(miso_w[0]));
    spi_master #(.DIV(2), .WIDTH(8)) u_div2 (
        .clk(clk), .rst(rst[1]), .start(start[1]), .data_in(din[1]), .data_out(dout_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .ss(ss_w[1]), .sclk(sclk_w[1]), .mosi(mosi_w[1]),
        .miso(miso_w[1]));
    spi_master #(.DIV(1), .WIDTH(8)) u_div1 (
        .clk(clk), .rst(rst[2]), .start(start[2]), .data_in(din[2]), .data_out(dout_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .ss(ss_w[2]), .sclk(sclk_w[2]), .mosi(mosi_w[2]),
        .miso(miso_w[2]));

    typedef struct packed {
        logic       act;
        int         t;      // cycle number within the current transfer, 1 = first ss-low cycle
        logic [7:0] d;
        logic [7:0] rx;
        logic [7:0] dout;
        logic       done;
    } mstate_t;

    mstate_t ms [3];

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : (i == 1) ? 2 : 1;
    endfunction

    // sclk is high for D cycles starting at 2D+1, every 2D cycles, eight times.
    function automatic logic exp_sclk(input int dv, input int t);
        return (t >= 2*dv + 1) && (t <= 17*dv) && ((((t - 2*dv - 1) / dv) % 2) == 0);
    endfunction

    function automatic logic exp_mosi(input int dv, input int t, input logic [7:0] d);
        int f;
        f = (t < 3*dv + 1) ? 0 : (t - 3*dv - 1) / (2*dv) + 1;
        if (f > 7) f = 7;
        return d[7 - f];
    endfunction

    function automatic logic pat_bit(input mstate_t s, input int dv, input logic [7:0] p);
        int k;
        k = (s.act && s.t >= 2*dv) ? (s.t - 2*dv) / (2*dv) : 0;
        if (k > 7) k = 7;
        return p[7 - k];
    endfunction

    function automatic logic exp_miso(input int i, input mstate_t s);
        if (mode[i] == 0) return exp_mosi(div_of(i), s.t, s.d);
        if (mode[i] == 1) return 1'b1;
        return pat_bit(s, div_of(i), pat[i]);
    endfunction

    function automatic mstate_t step(input mstate_t s, input int dv, input logic r, input logic st,
                                     input logic [7:0] di, input logic mi);
        mstate_t n;
        n = s;
        n.done = 1'b0;
        if (r) begin
            n.act = 1'b0; n.t = 0; n.dout = 8'h00;
            return n;
        end
        if (s.act) begin
            if (s.t >= 2*dv && s.t <= 16*dv && ((s.t - 2*dv) % (2*dv)) == 0)
                n.rx = {s.rx[6:0], mi};
            if (s.t == 18*dv) begin
                n.done = 1'b1; n.dout = n.rx; n.act = 1'b0;
`ifdef SPI_MASTER_BURST_EN
                if (st) begin
                    n.act = 1'b1; n.t = dv + 1; n.d = di; n.rx = 8'h00;
                end
`endif
            end else begin
                n.t = s.t + 1;
            end
        end else if (st) begin
            n.act = 1'b1; n.t = 1; n.d = di; n.rx = 8'h00;
        end
        return n;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_miso
        assign miso_w[g] = (mode[g] == 0) ? mosi_w[g] :
                           (mode[g] == 1) ? 1'b1 : pat_bit(ms[g], div_of(g), pat[g]);
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            ms[i] <= step(ms[i], div_of(i), rst[i], start[i], din[i], exp_miso(i, ms[i]));
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                mstate_t s;
                int      dv;
                s  = ms[i];
                dv = div_of(i);
                check($sformatf("u%0d.busy", i), 32'(busy_w[i]), 32'(s.act));
                check($sformatf("u%0d.ss", i), 32'(ss_w[i]), 32'(!s.act));
                check($sformatf("u%0d.done", i), 32'(done_w[i]), 32'(s.done));
                check($sformatf("u%0d.sclk", i), 32'(sclk_w[i]), 32'(s.act && exp_sclk(dv, s.t)));
                check($sformatf("u%0d.mosi", i), 32'(mosi_w[i]),
                      32'(s.act ? exp_mosi(dv, s.t, s.d) : 1'b0));
                check($sformatf("u%0d.data_out", i), 32'(dout_w[i]), 32'(s.dout));
            end
        end
    end

    typedef struct packed {
        int         done_c;
        int         nrise;
        int         first_rise;
        int         last_rise;
        int         busy_cnt;
        logic       ss_c1;
        logic [7:0] mosi_rises;
        logic [7:0] dout;
        logic [3:0] rst_snap;   // {ss, sclk, mosi, busy} one cycle after reset
        logic [7:0] rst_dout;
    } res_t;

    // Called at the negedge of cycle 0; start is raised here and observed from cycle 1 on.
    task automatic xfer(input int i, input logic [7:0] data, input int p1, input int p2,
                        input int rst_at, input int maxc, output res_t r);
        logic prev;
        r = '0;
        r.done_c = -1;
        r.first_rise = -1;
        prev = 1'b0;
        start[i] = 1'b1;
        din[i] = data;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            start[i] = (c == p1) || (c == p2);
            din[i] = 8'($urandom);
            if (c == rst_at) rst[i] = 1'b1;
            if (rst_at > 0 && c == rst_at + 1) begin
                rst[i] = 1'b0;
                r.rst_snap = {ss_w[i], sclk_w[i], mosi_w[i], busy_w[i]};
                r.rst_dout = dout_w[i];
            end
            if (c == 1) r.ss_c1 = ss_w[i];
            if (busy_w[i]) r.busy_cnt++;
            if (sclk_w[i] && !prev) begin
                r.nrise++;
                if (r.first_rise < 0) r.first_rise = c;
                r.last_rise = c;
                r.mosi_rises = {r.mosi_rises[6:0], mosi_w[i]};
            end
            prev = sclk_w[i];
            if (done_w[i]) begin
                r.done_c = c;
                r.dout = dout_w[i];
                break;
            end
        end
        start[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        rst = 3'b111;
        start = 3'b000;
        for (int i = 0; i < 3; i++) begin
            din[i] = 8'h00;
            mode[i] = 0;
            pat[i] = 8'h00;
        end
        mode[2] = 2;
        pat[2] = 8'h5A;
        repeat (3) @(negedge clk);
        rst = 3'b000;
        chk_en = 1'b1;
        check("reset.ss", 32'(ss_w), 32'h7);
        check("reset.busy", 32'(busy_w), 32'h0);
        check("reset.sclk_mosi", 32'({sclk_w, mosi_w}), 32'h0);
        check("reset.dout4", 32'(dout_w[0]), 32'h0);
        repeat (2) @(negedge clk);

        // DIV=4 loopback 0xA5
        xfer(0, 8'hA5, -1, -1, -1, 200, r);
        check("t1.ss_c1", 32'(r.ss_c1), 32'h0);
        check("t1.nrise", r.nrise, 8);
        check("t1.first_rise", r.first_rise, 9);
        check("t1.last_rise", r.last_rise, 65);
        check("t1.done_c", r.done_c, 73);
        check("t1.busy_cnt", r.busy_cnt, 72);
        check("t1.dout", 32'(r.dout), 32'hA5);
        check("t1.mosi_rises", 32'(r.mosi_rises), 32'hA5);
        repeat (3) @(negedge clk);

        // DIV=4, miso=1, 0x3C
        mode[0] = 1;
        xfer(0, 8'h3C, -1, -1, -1, 200, r);
        check("t2.mosi_rises", 32'(r.mosi_rises), 32'h3C);
        check("t2.dout", 32'(r.dout), 32'hFF);
        @(negedge clk);
        check("t2.idle_mosi_sclk", 32'({mosi_w[0], sclk_w[0]}), 32'h0);
        mode[0] = 0;
        repeat (2) @(negedge clk);

        // DIV=2, starts while busy ignored, restart in done cycle
        xfer(1, 8'h81, 5, 20, -1, 200, r);
        check("t3.done_c", r.done_c, 37);
        check("t3.dout", 32'(r.dout), 32'h81);
        xfer(1, 8'h42, -1, -1, -1, 200, r);
        check("t3.restart_ss_c1", 32'(r.ss_c1), 32'h0);
        check("t3.restart_done_c", r.done_c, 37);
        check("t3.restart_dout", 32'(r.dout), 32'h42);
        repeat (3) @(negedge clk);

        // DIV=4, reset in cycle 30 mid-XFER
        xfer(0, 8'hE7, -1, -1, 30, 120, r);
        check("t4.rst_snap", 32'(r.rst_snap), 32'b1000);
        check("t4.rst_dout", 32'(r.rst_dout), 32'h0);
        check("t4.no_done", r.done_c, -1);
        xfer(0, 8'h69, -1, -1, -1, 200, r);
        check("t4.after_done_c", r.done_c, 73);
        check("t4.after_dout", 32'(r.dout), 32'h69);
        repeat (3) @(negedge clk);

        // DIV=1, miso pattern 0x5A
        xfer(2, 8'hC3, -1, -1, -1, 100, r);
        check("t5.done_c", r.done_c, 19);
        check("t5.dout", 32'(r.dout), 32'h5A);
        check("t5.mosi_rises", 32'(r.mosi_rises), 32'hC3);
        repeat (3) @(negedge clk);

`ifdef SPI_MASTER_BURST_EN
        begin
            int         dc [2];
            logic [7:0] dd [2];
            int         nd;
            int         ss_viol;
            nd = 0;
            ss_viol = 0;
            dc[0] = -1; dc[1] = -1; dd[0] = 8'h00; dd[1] = 8'h00;
            start[1] = 1'b1;
            din[1] = 8'h12;
            for (int c = 1; c <= 90; c++) begin
                @(negedge clk);
                din[1] = 8'h34;
                start[1] = (c <= 40);
                if (c <= 70 && ss_w[1]) ss_viol++;
                if (done_w[1] && nd < 2) begin
                    dc[nd] = c;
                    dd[nd] = dout_w[1];
                    nd++;
                end
            end
            start[1] = 1'b0;
            check("t6.ss_viol", ss_viol, 0);
            check("t6.done1_c", dc[0], 37);
            check("t6.done2_c", dc[1], 71);
            check("t6.dout1", 32'(dd[0]), 32'h12);
            check("t6.dout2", 32'(dd[1]), 32'h34);
        end
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Byte-wide SPI master for the expander subsystem. It is the initiator end of the serial link whose target is the on-chip SPI slave.
- Drives ss, sclk and mosi, and samples miso, in SPI mode 0 (CPOL=0, CPHA=0), MSB first.
- Core logic hands it a byte with a start/done handshake and gets back the byte received during the same transfer.

Parameters:
- DIV, 4: sclk half-period in clk cycles; legal range 1..255.
- WIDTH, 8: bits per transfer. Only 8 is verified.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a transfer; sampled only when the block is idle
- data_in  input  WIDTH  byte to transmit; captured in the cycle start is accepted
- data_out  output  WIDTH  byte received; updated in the done cycle, held otherwise
- busy  output  1  high while a transfer is in progress
- done  output  1  single-cycle pulse when a transfer completes
- ss  output  1  slave select, active low
- sclk  output  1  serial clock, idle low
- mosi  output  1  serial data out
- miso  input  1  serial data in; assumed synchronous to clk

Behaviour:
- Reset (rst high at a clk edge, any state):
  - Next cycle: ss=1, sclk=0, mosi=0, busy=0, done=0, data_out=0, state=IDLE.
  - A transfer in progress is abandoned. No done pulse is generated for it.
- States: IDLE, LEAD, XFER, TRAIL. Cycle 0 is the cycle in which start=1 is sampled in IDLE.
- IDLE:
  - Outputs: ss=1, sclk=0, busy=0.
  - mosi holds 0.
  - On start: load the tx shift register from data_in, clear the rx shift register and bit counter, go to LEAD.
- LEAD, cycles 1..DIV:
  - ss=0, busy=1, sclk=0.
  - mosi = data_in[WIDTH-1].
  - After DIV cycles, go to XFER.
- XFER, cycles DIV+1..(2*WIDTH+1)*DIV:
  - A half-period counter counts DIV cycles, then toggles sclk.
  - Rising sclk edge (0->1): the same clk edge shifts miso into the LSB of the rx shift register.
  - Falling sclk edge (1->0): shift tx left and present the next bit on mosi; the bit counter increments.
  - After the WIDTH-th falling edge, go to TRAIL with sclk=0.
  - First sclk rise is in cycle 2*DIV+1.
- TRAIL, next DIV cycles:
  - ss=0, sclk=0, mosi holds the last value.
- Done cycle, 18*DIV+1 for WIDTH=8:
  - ss=1, busy=0, done=1, data_out=rx shift register, state=IDLE.
- Back-to-back transfers:
  - start accepted in the done cycle begins a new transfer; ss is low again the following cycle.
  - Minimum ss-high gap is 1 cycle.
- start while busy is ignored; it is not queued.
- data_in changes after capture have no effect on the transfer in progress.
- DIV=1: sclk toggles every clk cycle; the same state sequence applies.
- Counters are sized with $clog2(DIV+1) and $clog2(WIDTH+1).
  - Half-period counter wraps to 0 on each toggle.
  - Bit counter clears only in IDLE/LEAD.

Optional Feature:
- SPI_MASTER_BURST_EN defined:
  - start=1 in the last TRAIL cycle chains a transfer.
  - Next cycle: done=1, data_out updated, busy stays 1, ss stays 0, data_in loaded, mosi=data_in[WIDTH-1], state=XFER (LEAD is skipped).
  - Successive done pulses are spaced 17*DIV cycles apart.
  - start sampled in the done cycle itself still behaves as in the non-burst case.
- SPI_MASTER_BURST_EN undefined:
  - start is ignored in every state except IDLE.
  - ss always returns high for at least 1 cycle between transfers.

Test Plan:
- Loopback, DIV=4, miso tied to mosi, start with data_in=0xA5:
  - ss falls in cycle 1.
  - Exactly 8 sclk rising edges; first in cycle 9, spaced 8 cycles apart.
  - done=1 in cycle 73 only; data_out=0xA5; busy high for cycles 1..72.
- DIV=4, miso=1 constant, data_in=0x3C:
  - mosi at successive sclk rises = 0,0,1,1,1,1,0,0.
  - data_out=0xFF at done.
  - mosi=0 and sclk=0 after return to IDLE.
- DIV=2, start pulsed again in cycles 5 and 20 during a 0x81 transfer:
  - Both pulses ignored; exactly one done, in cycle 37.
  - Restart accepted in the done cycle gives ss low in cycle 38.
- DIV=4, rst asserted in cycle 30 mid-XFER:
  - Cycle 31: ss=1, sclk=0, mosi=0, busy=0, data_out=0.
  - No done pulse.
  - A new start after reset completes normally with the correct data.
- DIV=1, miso driven with 0x5A MSB-first aligned to sclk rises:
  - done in cycle 19; data_out=0x5A.
- SPI_MASTER_BURST_EN, DIV=2, start held high across two transfers (0x12, 0x34):
  - ss stays low throughout.
  - Done pulses in cycles 37 and 71.
  - Loopback data_out=0x12, then 0x34.
